// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed data priority.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_mode,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_dm_q, gnt_dm_d;
  logic          err_q, err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [2:0]    mem_mode_q, mem_mode_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          pick_dm;
  logic          timeout_hit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_dm_q, last_dm_d;
`endif

  // Abort fires on the cycle whose increment would make the count reach TIMEOUT_CYC.
  assign timeout_hit = (TIMEOUT_CYC != 0) &&
                       ({{(32-CW){1'b0}}, cnt_q} == TIMEOUT_CYC - 32'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dm_d    = gnt_dm_q;
    err_d       = err_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_we_d    = mem_we_q;
    mem_mode_d  = mem_mode_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_dm_d   = last_dm_q;
    pick_dm     = dm_req & (~if_req | ~last_dm_q);
`else
    pick_dm     = dm_req;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_dm) begin
          state_d     = DATA;
          gnt_dm_d    = 1'b1;
          cnt_d       = '0;
          mem_we_d    = dm_we;
          mem_mode_d  = dm_mode;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_dm_d   = 1'b1;
`endif
        end else if (if_req) begin
          state_d     = FETCH;
          gnt_dm_d    = 1'b0;
          cnt_d       = '0;
          mem_we_d    = 1'b0;
          mem_mode_d  = 3'b010;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_dm_d   = 1'b0;
`endif
        end
      end
      FETCH, DATA: begin
        // mem_ready has precedence over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_d = DONE;
          if (state_q == DATA) dm_rdata_d = mem_rdata;
          else                 if_rdata_d = mem_rdata;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (state_q == DATA) dm_rdata_d = '0;
          else                 if_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d == FETCH) || (state_d == DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_dm_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mode_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dm_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_dm_q    <= gnt_dm_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_mode_q  <= mem_mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dm_q   <= last_dm_d;
`endif
    end
  end

  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = (state_q == DONE) & ~gnt_dm_q;
  assign dm_valid  = (state_q == DONE) & gnt_dm_q;
  assign bus_err   = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_mode  = mem_mode_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15: max cycles waiting for mem_ready; 0 disables the timeout.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch request, held until if_valid.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetched word, valid with if_valid.
REQ-007 if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 dm_req  input  1  data request, held until dm_valid.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_mode  input  3  funct3 access size/sign, passed through.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_rdata  output  32  load data, valid with dm_valid.
REQ-014 dm_valid  output  1  one-cycle data completion pulse.
REQ-015 mem_req, mem_we  output  1 each  shared-port request / write enable.
REQ-016 mem_mode  output  3; mem_addr, mem_wdata  output  32  shared-port fields.
REQ-017 mem_rdata  input  32; mem_ready  input  1  port completion, sampled while mem_req=1.
REQ-018 stall_if, stall_mem  output  1  pipeline stalls.
REQ-019 bus_err  output  1  one-cycle timeout pulse.

Function
REQ-020 FSM states IDLE, FETCH, DATA, DONE; one transaction in flight at a time.
REQ-021 IDLE: dm_req=1 -> DATA; else if_req=1 -> FETCH; else stay (fixed priority, see REQ-034); on grant, latch addr/we/mode/wdata (fetch: we=0, mode=3'b010).
REQ-022 mem_* outputs are registered: mem_req=1 for every cycle in FETCH/DATA, 0 otherwise; fields stable while mem_req=1.
REQ-023 FETCH/DATA: mem_ready=1 at edge -> capture mem_rdata into the granted requester's rdata register, go DONE.
REQ-024 DONE: exactly one cycle; granted requester's valid=1; next state IDLE unconditionally.
REQ-025 Latency: req high in IDLE cycle N, mem_ready high in N+1 -> valid in N+2, IDLE in N+3; min 3 cycles per access.
REQ-026 if_rdata/dm_rdata hold last captured value until next completion for that requester.
REQ-027 Timeout counter: cleared on entry to FETCH/DATA, +1 per cycle without mem_ready; reaching TIMEOUT_CYC -> abort to DONE, rdata forced 32'h0, bus_err=1 in DONE, valid still pulses.
REQ-028 mem_ready and timeout in same cycle: mem_ready wins, no bus_err.
REQ-029 Requester dropping req mid-transaction: transaction still completes, valid still pulses.
REQ-030 mem_ready outside FETCH/DATA is ignored.
REQ-031 stall_if = if_req & ~if_valid; stall_mem = dm_req & ~dm_valid (combinational).

Reset
REQ-032 reset=1 immediately forces IDLE, counter 0, last-grant flag = fetch, all outputs 0 including rdata registers; in-flight transaction discarded without valid.
REQ-033 First arbitration occurs on the first rising edge after reset deasserts.

Configuration
REQ-034 MEM_ARB_ROUND_ROBIN_EN undefined: IDLE with both requests grants data (fixed priority).
REQ-035 MEM_ARB_ROUND_ROBIN_EN defined: IDLE with both requests grants the requester not granted last (last-grant flag updated on every grant); single request behaves as REQ-021.

Verification
REQ-036 if_req=1, if_addr=32'h40, mem_ready=1 first mem_req cycle, mem_rdata=32'h00500093 -> mem_addr=32'h40, if_valid pulse 2 cycles after req, if_rdata=32'h00500093.
REQ-037 dm_req=1, dm_we=1, dm_mode=3'b000, dm_addr=32'h104, dm_wdata=32'hAB -> mem_we=1, mem_mode=3'b000, mem_addr=32'h104, mem_wdata=32'hAB, dm_valid pulse.
REQ-038 if_req and dm_req together for 4 transactions -> grants D,D,D,D (no macro); D,F,D,F (macro defined, reset state last=fetch); stall_if high until its grant.
REQ-039 TIMEOUT_CYC=15, mem_ready held 0 -> mem_req high 15 cycles, then bus_err and valid pulse together, rdata=32'h0, FSM back to IDLE.
REQ-040 reset asserted during DATA with mem_ready=0 -> mem_req drops same cycle, no dm_valid, next fetch after release completes normally.
